// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory access stage: access sizes,
// FSM states, and the byte-lane encoding used on the data-memory bus.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE     = 2'b00,
    MEM_HALF     = 2'b01,
    MEM_WORD     = 2'b10,
    MEM_WORD_ALT = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUSY  = 2'b01,
    ST_DONE  = 2'b10,
    ST_FAULT = 2'b11
  } mas_state_t;

  localparam int DEFAULT_MEM_TIMEOUT = 16;

  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] lane);
    logic mis;
    case (size)
      MEM_BYTE: mis = 1'b0;
      MEM_HALF: mis = lane[0];
      default:  mis = (lane != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] byte_enable(input mem_size_t size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      MEM_BYTE: be = 4'b0001 << lane;
      MEM_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      default:  be = 4'b1111;
    endcase
    return be;
  endfunction

  // Narrow stores are replicated across the word so the byte enables alone pick the lane.
  function automatic logic [31:0] store_lanes(input mem_size_t size, input logic [31:0] data);
    logic [31:0] lanes;
    case (size)
      MEM_BYTE: lanes = {4{data[7:0]}};
      MEM_HALF: lanes = {2{data[15:0]}};
      default:  lanes = data;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load formatting: picks the addressed byte/half lane out of the bus word and
// sign- or zero-extends it to 32 bits.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  mem_size_t   size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        byte_sign;
  logic        half_sign;

  always_comb begin
    byte_sel  = rdata[{lane, 3'b000} +: 8];
    half_sel  = lane[1] ? rdata[31:16] : rdata[15:0];
    byte_sign = ~is_unsigned & byte_sel[7];
    half_sign = ~is_unsigned & half_sel[15];
    case (size)
      MEM_BYTE: result = {{24{byte_sign}}, byte_sel};
      MEM_HALF: result = {{16{half_sign}}, half_sel};
      default:  result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: runs one req/ack data-memory transaction per load/store,
// stalls the pipeline while it is outstanding, and raises a sticky fault.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic        halted_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        fault,
  output logic        halted_out
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  mas_state_t    state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic [31:0]   read_data_reg;

  // Request fields captured on entry to BUSY so the bus stays stable.
  logic          req_we_reg;
  logic          req_load_reg;
  logic [29:0]   req_word_reg;
  logic [3:0]    req_be_reg;
  logic [31:0]   req_wdata_reg;
  mem_size_t     req_size_reg;
  logic          req_unsigned_reg;
  logic [1:0]    req_lane_reg;

  mem_size_t     size_in;
  logic          access;
  logic          misaligned;
  logic          start;
  logic          capture;
  logic [31:0]   load_result;

  assign size_in    = mem_size_t'(mem_size);
  assign access     = in_valid & (mem_read | mem_write) & ~halted_in;
  assign misaligned = is_misaligned(size_in, addr[1:0]);
  assign start      = (state_reg == ST_IDLE) & access & ~misaligned;

  mem_load_align u_load_align (
    .rdata       (dmem_rdata),
    .lane        (req_lane_reg),
    .size        (req_size_reg),
    .is_unsigned (req_unsigned_reg),
    .result      (load_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_we_reg       <= 1'b0;
      req_load_reg     <= 1'b0;
      req_word_reg     <= '0;
      req_be_reg       <= '0;
      req_wdata_reg    <= '0;
      req_size_reg     <= MEM_BYTE;
      req_unsigned_reg <= 1'b0;
      req_lane_reg     <= '0;
    end else if (start) begin
      req_we_reg       <= mem_write;
      req_load_reg     <= mem_read;
      req_word_reg     <= addr[31:2];
      req_be_reg       <= byte_enable(size_in, addr[1:0]);
      req_wdata_reg    <= store_lanes(size_in, store_data);
      req_size_reg     <= size_in;
      req_unsigned_reg <= mem_unsigned;
      req_lane_reg     <= addr[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data_reg <= '0;
    end else if (capture) begin
      read_data_reg <= load_result;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    capture    = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_be    = '0;
    stall      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        count_next = '0;
        if (access) begin
          if (misaligned) begin
            state_next = ST_FAULT;
          end else begin
            dmem_req   = 1'b1;
            dmem_we    = mem_write;
            dmem_addr  = {addr[31:2], 2'b00};
            dmem_be    = byte_enable(size_in, addr[1:0]);
            dmem_wdata = store_lanes(size_in, store_data);
            stall      = 1'b1;
            state_next = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        dmem_req   = 1'b1;
        dmem_we    = req_we_reg;
        dmem_addr  = {req_word_reg, 2'b00};
        dmem_be    = req_be_reg;
        dmem_wdata = req_wdata_reg;
        stall      = 1'b1;
        // Ack takes priority over a timeout landing in the same cycle.
        if (dmem_ack) begin
          capture    = req_load_reg;
          count_next = '0;
          state_next = ST_DONE;
        end else if (count_reg == CNT_LAST) begin
          state_next = ST_FAULT;
        end else begin
          count_next = count_reg + CW'(1);
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_FAULT;
      end
    endcase
    // Keep the bus quiet for the whole reset pulse, even with a live EX/MEM entry.
    if (!rst_n) begin
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = '0;
      dmem_wdata = '0;
      dmem_be    = '0;
      stall      = 1'b0;
    end
  end

  assign read_data  = read_data_reg;
  assign fault      = (state_reg == ST_FAULT);
  assign halted_out = halted_in | fault;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: bus requests and load results are
// predicted into queues at drive time and compared when the DUT produces them.
module tb_mem_access_unit;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        halted_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [31:0] read_data;
  logic        stall;
  logic        fault;
  logic        halted_out;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .addr         (addr),
    .store_data   (store_data),
    .halted_in    (halted_in),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_be      (dmem_be),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack),
    .read_data    (read_data),
    .stall        (stall),
    .fault        (fault),
    .halted_out   (halted_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } bus_exp_t;

  bus_exp_t    bus_q[$];
  logic [31:0] rd_q[$];
  bus_exp_t    cur_bus;
  logic [31:0] last_rd;
  int          checks;
  int          failures;
  logic        req_prev;
  logic        stall_prev;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fmt_load(input logic [31:0] rd, input logic [1:0] sz,
                                           input logic uns, input logic [1:0] lane);
    logic [31:0] sh;
    logic [31:0] res;
    sh = rd >> (8 * lane);
    if (sz == 2'b00)      res = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
    else if (sz == 2'b01) res = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
    else                  res = rd;
    return res;
  endfunction

  // Monitor: compares bus requests and DONE-cycle read data against the queues.
  always @(negedge clk) begin
    if (!rst_n) begin
      req_prev   = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (dmem_req && !req_prev) begin
        if (bus_q.size() == 0) begin
          check_val("unexpected_req", 32'd1, 32'd0);
        end else begin
          cur_bus = bus_q.pop_front();
          check_val("req_addr", dmem_addr, cur_bus.addr);
          check_val("req_be", {28'h0, dmem_be}, {28'h0, cur_bus.be});
          check_val("req_wdata", dmem_wdata, cur_bus.wdata);
          check_val("req_we", {31'h0, dmem_we}, {31'h0, cur_bus.we});
        end
      end else if (dmem_req && req_prev) begin
        check_val("hold_addr", dmem_addr, cur_bus.addr);
        check_val("hold_wdata", dmem_wdata, cur_bus.wdata);
      end
      if (stall_prev && !stall && !fault) begin
        if (rd_q.size() == 0) begin
          check_val("unexpected_done", 32'd1, 32'd0);
        end else begin
          check_val("read_data", read_data, rd_q.pop_front());
        end
      end
      req_prev   = dmem_req;
      stall_prev = stall;
    end
  end

  task automatic clear_inputs();
    in_valid     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_size     = 2'b00;
    mem_unsigned = 1'b0;
    addr         = '0;
    store_data   = '0;
    dmem_ack     = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    halted_in  = 1'b0;
    dmem_rdata = '0;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    last_rd = '0;
  endtask

  // ack_cycle: BUSY cycle (1-based) carrying the ack; -1 means never ack.
  task automatic drive_access(input string name, input logic rd, input logic wr,
                              input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [31:0] sd,
                              input logic [31:0] rdata, input int ack_cycle);
    bus_exp_t    e;
    logic [1:0]  lane;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        mis;
    int          kind;
    int          exp_stall;
    int          stall_cnt;
    int          c;
    lane = a[1:0];
    mis  = (sz == 2'b01 && lane[0]) || (sz[1] && lane != 2'b00);
    if (mis) kind = 2;
    else if (ack_cycle < 1 || ack_cycle > TIMEOUT) kind = 1;
    else kind = 0;
    if (sz == 2'b00) begin
      be = 4'b0001 << lane;
      wd = {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
    end else if (sz == 2'b01) begin
      be = lane[1] ? 4'b1100 : 4'b0011;
      wd = {sd[15:0], sd[15:0]};
    end else begin
      be = 4'b1111;
      wd = sd;
    end
    if (kind != 2) begin
      e.addr  = {a[31:2], 2'b00};
      e.be    = be;
      e.wdata = wd;
      e.we    = wr;
      bus_q.push_back(e);
    end
    if (kind == 0) begin
      if (rd) last_rd = fmt_load(rdata, sz, uns, lane);
      rd_q.push_back(last_rd);
    end
    exp_stall = (kind == 0) ? ack_cycle + 1 : (kind == 1) ? TIMEOUT + 1 : 0;

    @(posedge clk);
    #1;
    in_valid     = 1'b1;
    mem_read     = rd;
    mem_write    = wr;
    mem_size     = sz;
    mem_unsigned = uns;
    addr         = a;
    store_data   = sd;
    dmem_rdata   = rdata;
    stall_cnt    = 0;
    c            = 0;
    forever begin
      dmem_ack = (c == ack_cycle);
      @(negedge clk);
      if (!stall) break;
      stall_cnt++;
      @(posedge clk);
      #1;
      c++;
      if (c > 60) begin
        check_val({name, "_stall_bound"}, 32'd1, 32'd0);
        break;
      end
    end
    dmem_ack = 1'b0;
    check_val({name, "_stall_cycles"}, stall_cnt, exp_stall);
    check_val({name, "_req_after"}, {31'h0, dmem_req}, 32'd0);
    @(posedge clk);
    #1;
    clear_inputs();
    @(negedge clk);
    check_val({name, "_fault"}, {31'h0, fault}, {31'h0, kind != 0});
    check_val({name, "_halted_out"}, {31'h0, halted_out}, {31'h0, kind != 0});
    $display("txn %s addr=%h stall=%0d fault=%0b read_data=%h", name, a, stall_cnt, fault, read_data);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    last_rd  = '0;
    req_prev   = 1'b0;
    stall_prev = 1'b0;
    apply_reset();
    @(negedge clk);
    check_val("rst_read_data", read_data, 32'h0);
    check_val("rst_fault", {31'h0, fault}, 32'h0);
    check_val("rst_req", {31'h0, dmem_req}, 32'h0);
    check_val("rst_stall", {31'h0, stall}, 32'h0);
    check_val("rst_bus", dmem_addr | dmem_wdata | {28'h0, dmem_be} | {31'h0, dmem_we}, 32'h0);
    $display("txn reset read_data=%h fault=%0b", read_data, fault);

    drive_access("lw_100", 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 2);
    drive_access("lb_103", 1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80123456, 1);
    drive_access("lbu_103", 1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80123456, 1);
    drive_access("sh_202", 1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 32'h11111111, 1);
    drive_access("sb_601", 1'b0, 1'b1, 2'b00, 1'b0, 32'h601, 32'h123456A5, 32'h0, 3);
    drive_access("sw_700", 1'b0, 1'b1, 2'b10, 1'b0, 32'h700, 32'hCAFEF00D, 32'h0, 2);
    drive_access("lw11_704", 1'b1, 1'b0, 2'b11, 1'b0, 32'h704, 32'h0, 32'h13579BDF, 1);
    for (int i = 0; i < 6; i++) begin
      logic [1:0] sz;
      logic [1:0] lane;
      sz   = (i % 2 == 0) ? 2'b00 : 2'b01;
      lane = (sz == 2'b00) ? 2'($urandom_range(0, 3)) : {1'($urandom_range(0, 1)), 1'b0};
      drive_access($sformatf("rand%0d", i), 1'b1, 1'b0, sz, 1'($urandom_range(0, 1)),
                   32'h500 + 32'(4 * i) + {30'h0, lane}, 32'h0, $urandom, $urandom_range(1, 3));
    end

    // Upstream halt suppresses the access entirely.
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    mem_read  = 1'b1;
    mem_size  = 2'b10;
    addr      = 32'h300;
    halted_in = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_val("halt_req", {31'h0, dmem_req}, 32'h0);
      check_val("halt_stall", {31'h0, stall}, 32'h0);
      check_val("halt_out", {31'h0, halted_out}, 32'h1);
    end
    @(posedge clk);
    #1;
    clear_inputs();
    halted_in = 1'b0;
    $display("txn halted_in addr=00000300 req=%0b", dmem_req);

    // Ack while idle must not disturb anything.
    @(posedge clk);
    #1;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    check_val("stray_ack_stall", {31'h0, stall}, 32'h0);
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    check_val("stray_ack_read_data", read_data, last_rd);
    $display("txn stray_ack read_data=%h", read_data);

    drive_access("ack16", 1'b1, 1'b0, 2'b10, 1'b0, 32'h800, 32'h0, 32'h0BADF00D, TIMEOUT);
    drive_access("timeout", 1'b1, 1'b0, 2'b10, 1'b0, 32'h804, 32'h0, 32'h12345678, -1);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    mem_read = 1'b1;
    mem_size = 2'b10;
    addr     = 32'h808;
    @(negedge clk);
    check_val("fault_no_req", {31'h0, dmem_req}, 32'h0);
    check_val("fault_sticky", {31'h0, fault}, 32'h1);
    check_val("fault_read_data", read_data, last_rd);
    $display("txn fault_sticky fault=%0b", fault);

    apply_reset();
    drive_access("lw_101", 1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 1);

    // Asynchronous reset in the middle of a transaction.
    apply_reset();
    begin
      bus_exp_t e;
      e.addr  = 32'h400;
      e.be    = 4'b1111;
      e.wdata = 32'h0;
      e.we    = 1'b0;
      bus_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid   = 1'b1;
    mem_read   = 1'b1;
    mem_size   = 2'b10;
    addr       = 32'h400;
    dmem_rdata = 32'hA5A5A5A5;
    repeat (3) @(posedge clk);
    #2;
    check_val("busy_before_rst", {31'h0, dmem_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_val("rst_busy_req", {31'h0, dmem_req}, 32'h0);
    check_val("rst_busy_stall", {31'h0, stall}, 32'h0);
    clear_inputs();
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    last_rd = '0;
    @(negedge clk);
    check_val("post_rst_read_data", read_data, 32'h0);
    check_val("post_rst_flags", {29'h0, dmem_req, stall, fault}, 32'h0);
    check_val("post_rst_bus", dmem_addr | dmem_wdata | {28'h0, dmem_be} | {31'h0, dmem_we}, 32'h0);
    $display("txn reset_mid_busy req=%0b read_data=%h", dmem_req, read_data);

    check_val("bus_q_left", bus_q.size(), 32'd0);
    check_val("rd_q_left", rd_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access stage sitting between the EX/MEM pipeline register and the MEM/WB register. Takes the executed instruction's address, store data and access controls, runs a req/ack transaction on the data-memory bus, and produces the aligned, extended `read_data` that MEM/WB latches. While a transaction is outstanding it stalls the pipeline. Misaligned accesses and bus timeouts raise a sticky fault that merges into the halted path.

## Interface
- `TIMEOUT`, 16: cycles in BUSY without `dmem_ack` before fault.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: EX/MEM entry holds a real instruction.
- `mem_read` / `mem_write` in 1: load / store (never both).
- `mem_size` in 2: 00 byte, 01 half, 10 word; 11 treated as word.
- `mem_unsigned` in 1: zero-extend loads (else sign-extend).
- `addr` in 32: byte address (ALU result).
- `store_data` in 32: rt value, low bits significant.
- `halted_in` in 1: upstream halt.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out 32 (word-aligned), `dmem_wdata` out 32, `dmem_be` out 4.
- `dmem_rdata` in 32, `dmem_ack` in 1.
- `read_data` out 32: formatted load result (registered).
- `stall` out 1: freeze PC, IF/ID, ID/EX, EX/MEM; bubble into MEM/WB.
- `fault` out 1: sticky misaligned/timeout flag.
- `halted_out` out 1: `halted_in | fault`.

## Operation
- States: IDLE, BUSY, DONE, FAULT.
- Access = `in_valid & (mem_read | mem_write) & !halted_in`.
- Misaligned: half with `addr[0]`; word with `addr[1:0] != 0`.
- IDLE: access & aligned -> drive `dmem_req`, go BUSY, `stall`=1 combinationally. Access & misaligned -> no req, set `fault`, go FAULT. Otherwise `stall`=0, stay.
- BUSY: `dmem_*` held stable, `stall`=1, counter increments. On `dmem_ack`: loads capture formatted data into `read_data`, go DONE. Counter reaching `TIMEOUT-1` without ack -> `fault`, FAULT.
- DONE: `stall`=0, inputs ignored (same EX/MEM entry still present), -> IDLE.
- FAULT: terminal until reset; no requests, `stall`=0.
- `dmem_addr` = `{addr[31:2],2'b00}`. `dmem_we` = `mem_write`.
- `dmem_be`: byte `1<<addr[1:0]`; half `addr[1]?1100:0011`; word `1111`.
- `dmem_wdata`: byte replicated ×4, half ×2, word as-is.
- Load format: select lane by `addr[1:0]`, extend per `mem_unsigned`.
- `read_data` updates only on load ack; stores and non-memory instructions leave it unchanged.

## Timing
- Reset: IDLE, counter 0, `read_data`=0, `fault`=0; `dmem_req`/`dmem_we`/`dmem_be`/`dmem_addr`/`dmem_wdata`/`stall` = 0. `halted_out` = `halted_in`.
- Minimum latency: request cycle + ack cycle (ack may come the cycle after req) + DONE cycle; `read_data` is valid in DONE, where MEM/WB samples it.
- Ack and timeout in the same cycle: ack wins.
- `dmem_ack` outside BUSY is ignored.
- Reset during BUSY: `dmem_req` drops immediately (async); no data captured.
- `halted_in` during BUSY: transaction completes normally.

## Structure
- Shared package `mem_pkg`: `mem_size_t` enum, `mas_state_t` enum, `DEFAULT_MEM_TIMEOUT`.
- Sub-module `mem_load_align`: combinational lane select plus extension (`dmem_rdata`, `addr[1:0]`, `mem_size`, `mem_unsigned` -> 32-bit result).

## Test plan
- Word load `addr`=0x100, ack after 2 cycles, rdata 0xDEADBEEF -> `stall` high 3 cycles, `read_data`=0xDEADBEEF in DONE.
- Signed byte load `addr`=0x103, rdata 0x80123456 -> `dmem_be`=1000, `read_data`=0xFFFFFF80; unsigned -> 0x00000080.
- Half store `addr`=0x202, data 0x0000ABCD -> `dmem_addr`=0x200, `be`=1100, `wdata`=0xABCDABCD, `we`=1; `read_data` unchanged.
- Word load `addr`=0x101 -> no `dmem_req`, `fault`=1, `halted_out`=1, `stall`=0.
- No ack for 16 BUSY cycles -> `fault`=1, FAULT; ack arriving on cycle 16 instead -> normal completion.
- `rst_n` low mid-BUSY -> `dmem_req`=0 immediately; after release, IDLE with all outputs 0.
